// File: rtl/ecap5_dwbarb_pkg.sv
// ecap5_dwbarb_pkg - shared types and widths for the two-initiator
// Wishbone B4 pipelined arbiter.
package ecap5_dwbarb_pkg;

  localparam int ADR_W = 32;
  localparam int DAT_W = 32;
  localparam int SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/ecap5_dwbarb.sv
// ecap5_dwbarb - merges two Wishbone B4 pipelined initiators (m0, m1) onto
// one shared master port. Ownership is held for a whole CYC and handed over
// without an idle cycle; the request/response paths are combinational.
// Build option: ECAP5_DWBARB_ROUND_ROBIN_EN selects a round-robin pointer for
// simultaneous requests; when undefined, m0 always wins contention.
module ecap5_dwbarb
  import ecap5_dwbarb_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [ADR_W-1:0] m0_wb_adr_i,
  input  logic [DAT_W-1:0] m0_wb_dat_i,
  output logic [DAT_W-1:0] m0_wb_dat_o,
  input  logic [SEL_W-1:0] m0_wb_sel_i,
  input  logic             m0_wb_we_i,
  input  logic             m0_wb_stb_i,
  input  logic             m0_wb_cyc_i,
  output logic             m0_wb_ack_o,
  output logic             m0_wb_stall_o,
  input  logic [ADR_W-1:0] m1_wb_adr_i,
  input  logic [DAT_W-1:0] m1_wb_dat_i,
  output logic [DAT_W-1:0] m1_wb_dat_o,
  input  logic [SEL_W-1:0] m1_wb_sel_i,
  input  logic             m1_wb_we_i,
  input  logic             m1_wb_stb_i,
  input  logic             m1_wb_cyc_i,
  output logic             m1_wb_ack_o,
  output logic             m1_wb_stall_o,
  output logic [ADR_W-1:0] s_wb_adr_o,
  output logic [DAT_W-1:0] s_wb_dat_o,
  output logic [SEL_W-1:0] s_wb_sel_o,
  output logic             s_wb_we_o,
  output logic             s_wb_stb_o,
  output logic             s_wb_cyc_o,
  input  logic [DAT_W-1:0] s_wb_dat_i,
  input  logic             s_wb_ack_i,
  input  logic             s_wb_stall_i,
  output logic [1:0]       grant_o
);

  arb_state_t state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       ptr_s;  // 0: m0 preferred on contention, 1: m1 preferred

  // Next owner: contention resolved by ptr_s, release hands straight over.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (m0_wb_cyc_i && m1_wb_cyc_i) begin
          state_d = ptr_s ? GRANT1 : GRANT0;
        end else if (m0_wb_cyc_i) begin
          state_d = GRANT0;
        end else if (m1_wb_cyc_i) begin
          state_d = GRANT1;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT0: begin
        if (!m0_wb_cyc_i) begin
          state_d = m1_wb_cyc_i ? GRANT1 : IDLE;
        end else begin
          state_d = GRANT0;
        end
      end
      GRANT1: begin
        if (!m1_wb_cyc_i) begin
          state_d = m0_wb_cyc_i ? GRANT0 : IDLE;
        end else begin
          state_d = GRANT1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered one-hot owner, updated on the same edge as the state.
  always_comb begin
    case (state_d)
      GRANT0:  grant_d = 2'b01;
      GRANT1:  grant_d = 2'b10;
      default: grant_d = 2'b00;
    endcase
  end

  // State and grant registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

`ifdef ECAP5_DWBARB_ROUND_ROBIN_EN
  logic ptr_q, ptr_d;

  // Entering a grant hands the preference to the other master.
  always_comb begin
    if ((state_d != state_q) && (state_d == GRANT0)) begin
      ptr_d = 1'b1;
    end else if ((state_d != state_q) && (state_d == GRANT1)) begin
      ptr_d = 1'b0;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_s = ptr_q;
`else
  assign ptr_s = 1'b0;
`endif

  // Combinational mux between the owner and the shared port; idle values otherwise.
  always_comb begin
    s_wb_adr_o    = '0;
    s_wb_dat_o    = '0;
    s_wb_sel_o    = '0;
    s_wb_we_o     = 1'b0;
    s_wb_stb_o    = 1'b0;
    s_wb_cyc_o    = 1'b0;
    m0_wb_dat_o   = '0;
    m0_wb_ack_o   = 1'b0;
    m0_wb_stall_o = 1'b1;
    m1_wb_dat_o   = '0;
    m1_wb_ack_o   = 1'b0;
    m1_wb_stall_o = 1'b1;
    case (state_q)
      GRANT0: begin
        s_wb_adr_o    = m0_wb_adr_i;
        s_wb_dat_o    = m0_wb_dat_i;
        s_wb_sel_o    = m0_wb_sel_i;
        s_wb_we_o     = m0_wb_we_i;
        s_wb_stb_o    = m0_wb_stb_i & m0_wb_cyc_i;
        s_wb_cyc_o    = m0_wb_cyc_i;
        m0_wb_dat_o   = s_wb_dat_i;
        m0_wb_ack_o   = s_wb_ack_i;
        m0_wb_stall_o = s_wb_stall_i;
      end
      GRANT1: begin
        s_wb_adr_o    = m1_wb_adr_i;
        s_wb_dat_o    = m1_wb_dat_i;
        s_wb_sel_o    = m1_wb_sel_i;
        s_wb_we_o     = m1_wb_we_i;
        s_wb_stb_o    = m1_wb_stb_i & m1_wb_cyc_i;
        s_wb_cyc_o    = m1_wb_cyc_i;
        m1_wb_dat_o   = s_wb_dat_i;
        m1_wb_ack_o   = s_wb_ack_i;
        m1_wb_stall_o = s_wb_stall_i;
      end
      default: begin
        s_wb_cyc_o = 1'b0;
      end
    endcase
  end

  assign grant_o = grant_q;

endmodule

// File: tb/tb_ecap5_dwbarb.sv
// tb_ecap5_dwbarb - directed bench for the two-initiator Wishbone arbiter.
// An ownership-level model predicts every output on each falling edge; a few
// literal expectations pin the model to hand-computed values.
module tb_ecap5_dwbarb;

  logic        clk, rst_n;
  logic [31:0] m0_wb_adr_i, m0_wb_dat_i, m0_wb_dat_o;
  logic [3:0]  m0_wb_sel_i;
  logic        m0_wb_we_i, m0_wb_stb_i, m0_wb_cyc_i, m0_wb_ack_o, m0_wb_stall_o;
  logic [31:0] m1_wb_adr_i, m1_wb_dat_i, m1_wb_dat_o;
  logic [3:0]  m1_wb_sel_i;
  logic        m1_wb_we_i, m1_wb_stb_i, m1_wb_cyc_i, m1_wb_ack_o, m1_wb_stall_o;
  logic [31:0] s_wb_adr_o, s_wb_dat_o, s_wb_dat_i;
  logic [3:0]  s_wb_sel_o;
  logic        s_wb_we_o, s_wb_stb_o, s_wb_cyc_o, s_wb_ack_i, s_wb_stall_i;
  logic [1:0]  grant_o;

  int checks = 0;
  int errors = 0;
  int own = 0;   // model owner: 0 none, 1 m0, 2 m1
  int ptr = 0;   // model preference: 0 m0, 1 m1
  int n_ack0 = 0;
  int n_ack1 = 0;
  logic ack_force = 1'b0;
  logic stall_force = 1'b0;
  logic [31:0] adr_log[$];

`ifdef ECAP5_DWBARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  ecap5_dwbarb dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_wb_adr_i(m0_wb_adr_i), .m0_wb_dat_i(m0_wb_dat_i), .m0_wb_dat_o(m0_wb_dat_o),
    .m0_wb_sel_i(m0_wb_sel_i), .m0_wb_we_i(m0_wb_we_i), .m0_wb_stb_i(m0_wb_stb_i),
    .m0_wb_cyc_i(m0_wb_cyc_i), .m0_wb_ack_o(m0_wb_ack_o), .m0_wb_stall_o(m0_wb_stall_o),
    .m1_wb_adr_i(m1_wb_adr_i), .m1_wb_dat_i(m1_wb_dat_i), .m1_wb_dat_o(m1_wb_dat_o),
    .m1_wb_sel_i(m1_wb_sel_i), .m1_wb_we_i(m1_wb_we_i), .m1_wb_stb_i(m1_wb_stb_i),
    .m1_wb_cyc_i(m1_wb_cyc_i), .m1_wb_ack_o(m1_wb_ack_o), .m1_wb_stall_o(m1_wb_stall_o),
    .s_wb_adr_o(s_wb_adr_o), .s_wb_dat_o(s_wb_dat_o), .s_wb_sel_o(s_wb_sel_o),
    .s_wb_we_o(s_wb_we_o), .s_wb_stb_o(s_wb_stb_o), .s_wb_cyc_o(s_wb_cyc_o),
    .s_wb_dat_i(s_wb_dat_i), .s_wb_ack_i(s_wb_ack_i), .s_wb_stall_i(s_wb_stall_i),
    .grant_o(grant_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] resp(input logic [31:0] a);
    return (a == 32'h0000_1000) ? 32'hDEAD_BEEF : (a ^ 32'hA5A5_0000);
  endfunction

  // Responder: accepts unstalled strobes, acks one cycle later, logs addresses.
  always @(posedge clk) begin : slave
    logic acc, af;
    logic [31:0] a;
    acc = s_wb_cyc_o && s_wb_stb_o && !s_wb_stall_i;
    af  = ack_force;
    a   = s_wb_adr_o;
    if (acc) adr_log.push_back(a);
    #1;
    s_wb_ack_i = acc | af;
    s_wb_dat_i = resp(a);
  end

  // Ownership model: who holds the bus after each edge.
  always @(posedge clk or negedge rst_n) begin : model
    int nxt;
    if (!rst_n) begin
      own = 0;
      ptr = 0;
    end else begin
      if (own == 0) begin
        if (m0_wb_cyc_i && m1_wb_cyc_i) nxt = (RR ? ptr : 0) + 1;
        else if (m0_wb_cyc_i) nxt = 1;
        else if (m1_wb_cyc_i) nxt = 2;
        else nxt = 0;
      end else begin
        logic mine, other;
        mine  = (own == 1) ? m0_wb_cyc_i : m1_wb_cyc_i;
        other = (own == 1) ? m1_wb_cyc_i : m0_wb_cyc_i;
        if (!mine) nxt = other ? (3 - own) : 0;
        else nxt = own;
      end
      if (nxt != 0 && nxt != own) ptr = (nxt == 1) ? 1 : 0;
      own = nxt;
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin : compare
    logic [31:0] x_adr, x_wd, x_d0, x_d1;
    logic [3:0]  x_sel;
    logic        x_we, x_stb, x_cyc, x_a0, x_a1, x_s0, x_s1;
    logic [1:0]  x_g;
    x_adr = 32'h0; x_wd = 32'h0; x_sel = 4'h0; x_we = 1'b0; x_stb = 1'b0; x_cyc = 1'b0;
    x_d0 = 32'h0; x_d1 = 32'h0; x_a0 = 1'b0; x_a1 = 1'b0; x_s0 = 1'b1; x_s1 = 1'b1;
    x_g = 2'b00;
    if (own == 1) begin
      x_adr = m0_wb_adr_i; x_wd = m0_wb_dat_i; x_sel = m0_wb_sel_i; x_we = m0_wb_we_i;
      x_stb = m0_wb_stb_i & m0_wb_cyc_i; x_cyc = m0_wb_cyc_i;
      x_d0 = s_wb_dat_i; x_a0 = s_wb_ack_i; x_s0 = s_wb_stall_i; x_g = 2'b01;
    end else if (own == 2) begin
      x_adr = m1_wb_adr_i; x_wd = m1_wb_dat_i; x_sel = m1_wb_sel_i; x_we = m1_wb_we_i;
      x_stb = m1_wb_stb_i & m1_wb_cyc_i; x_cyc = m1_wb_cyc_i;
      x_d1 = s_wb_dat_i; x_a1 = s_wb_ack_i; x_s1 = s_wb_stall_i; x_g = 2'b10;
    end
    chk("s_adr", s_wb_adr_o, x_adr);
    chk("s_wdat", s_wb_dat_o, x_wd);
    chk("s_sel", {28'h0, s_wb_sel_o}, {28'h0, x_sel});
    chk("s_we", {31'h0, s_wb_we_o}, {31'h0, x_we});
    chk("s_stb", {31'h0, s_wb_stb_o}, {31'h0, x_stb});
    chk("s_cyc", {31'h0, s_wb_cyc_o}, {31'h0, x_cyc});
    chk("m0_dat", m0_wb_dat_o, x_d0);
    chk("m1_dat", m1_wb_dat_o, x_d1);
    chk("m0_ack", {31'h0, m0_wb_ack_o}, {31'h0, x_a0});
    chk("m1_ack", {31'h0, m1_wb_ack_o}, {31'h0, x_a1});
    chk("m0_stall", {31'h0, m0_wb_stall_o}, {31'h0, x_s0});
    chk("m1_stall", {31'h0, m1_wb_stall_o}, {31'h0, x_s1});
    chk("grant", {30'h0, grant_o}, {30'h0, x_g});
    if (m0_wb_ack_o) n_ack0++;
    if (m1_wb_ack_o) n_ack1++;
  end

  initial begin : stim
    int i, guard;
    logic acc, stalled_once;
    int gseq[$];
    logic [1:0] last_g;
    int cnt0, cnt1;

    rst_n = 1'b0;
    m0_wb_adr_i = 32'h0; m0_wb_dat_i = 32'h1111_0000; m0_wb_sel_i = 4'h0;
    m0_wb_we_i = 1'b0; m0_wb_stb_i = 1'b0; m0_wb_cyc_i = 1'b0;
    m1_wb_adr_i = 32'h0; m1_wb_dat_i = 32'h2222_0000; m1_wb_sel_i = 4'h0;
    m1_wb_we_i = 1'b0; m1_wb_stb_i = 1'b0; m1_wb_cyc_i = 1'b0;
    s_wb_ack_i = 1'b0; s_wb_dat_i = 32'h0; s_wb_stall_i = 1'b0;

    // Reset values
    #3;
    chk("rst_grant", {30'h0, grant_o}, 32'h0);
    chk("rst_s_cyc", {31'h0, s_wb_cyc_o}, 32'h0);
    chk("rst_m0_stall", {31'h0, m0_wb_stall_o}, 32'h1);
    chk("rst_m1_stall", {31'h0, m1_wb_stall_o}, 32'h1);
    step(); step();
    rst_n = 1'b1;
    step();

    // Single master read of 0x1000 by m0
    m0_wb_cyc_i = 1'b1; m0_wb_stb_i = 1'b1; m0_wb_adr_i = 32'h0000_1000; m0_wb_sel_i = 4'hF;
    @(negedge clk);
    chk("t1_idle_stall", {31'h0, m0_wb_stall_o}, 32'h1);
    step();
    @(negedge clk);
    chk("t1_s_stb", {31'h0, s_wb_stb_o}, 32'h1);
    chk("t1_s_adr", s_wb_adr_o, 32'h0000_1000);
    chk("t1_grant", {30'h0, grant_o}, 32'h1);
    chk("t1_m1_stall", {31'h0, m1_wb_stall_o}, 32'h1);
    step();
    m0_wb_stb_i = 1'b0;
    @(negedge clk);
    chk("t1_m0_ack", {31'h0, m0_wb_ack_o}, 32'h1);
    chk("t1_m0_dat", m0_wb_dat_o, 32'hDEAD_BEEF);
    chk("t1_m1_ack", {31'h0, m1_wb_ack_o}, 32'h0);
    step();
    m0_wb_cyc_i = 1'b0;
    step(); step();

    // Simultaneous request after reset: m0 first, zero-idle handover to m1
    rst_n = 1'b0; step(); rst_n = 1'b1; step();
    m0_wb_cyc_i = 1'b1; m1_wb_cyc_i = 1'b1;
    step();
    @(negedge clk);
    chk("t2_first", {30'h0, grant_o}, 32'h1);
    step();
    m0_wb_cyc_i = 1'b0;
    @(negedge clk);
    chk("t2_release_cyc", {31'h0, s_wb_cyc_o}, 32'h0);
    step();
    @(negedge clk);
    chk("t2_handover", {30'h0, grant_o}, 32'h2);
    chk("t2_handover_cyc", {31'h0, s_wb_cyc_o}, 32'h1);
    step();
    m1_wb_cyc_i = 1'b0;
    step(); step();

    // Contention after m0 was last granted: pointer decides
    m0_wb_cyc_i = 1'b1; step(); step();
    m0_wb_cyc_i = 1'b0; step();
    m0_wb_cyc_i = 1'b1; m1_wb_cyc_i = 1'b1;
    step();
    @(negedge clk);
    chk("t3_contend", {30'h0, grant_o}, RR ? 32'h2 : 32'h1);
    step();
    m0_wb_cyc_i = 1'b0; m1_wb_cyc_i = 1'b0;
    step(); step();

    // Continuous requests with 3-cycle ownership: grants alternate
    m0_wb_cyc_i = 1'b1; m1_wb_cyc_i = 1'b1;
    cnt0 = 0; cnt1 = 0; last_g = 2'b00;
    repeat (24) begin
      logic [1:0] g;
      @(negedge clk);
      g = grant_o;
      if (g != 2'b00 && g != last_g) begin
        gseq.push_back(int'(g));
        last_g = g;
      end
      step();
      if (!m0_wb_cyc_i) m0_wb_cyc_i = 1'b1;
      else if (g[0]) begin cnt0++; if (cnt0 == 3) begin m0_wb_cyc_i = 1'b0; cnt0 = 0; end end
      if (!m1_wb_cyc_i) m1_wb_cyc_i = 1'b1;
      else if (g[1]) begin cnt1++; if (cnt1 == 3) begin m1_wb_cyc_i = 1'b0; cnt1 = 0; end end
    end
    chk("t4_ngrants", (gseq.size() >= 4) ? 32'h1 : 32'h0, 32'h1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t4_grant%0d", k), (k < gseq.size()) ? gseq[k] : 0, (k % 2 == 0) ? 32'h1 : 32'h2);
    end
    m0_wb_cyc_i = 1'b0; m1_wb_cyc_i = 1'b0;
    step(); step(); step();

    // Pipelined burst of 4 from m1 with a stall on beat 2
    adr_log.delete();
    n_ack0 = 0; n_ack1 = 0;
    m1_wb_cyc_i = 1'b1; m1_wb_we_i = 1'b1; m1_wb_sel_i = 4'hF;
    i = 0; guard = 0; stalled_once = 1'b0;
    while (i < 4 && guard < 40) begin
      m1_wb_adr_i = 32'h0000_2000 + (32'(i) << 2);
      m1_wb_dat_i = 32'h2222_0000 + 32'(i);
      m1_wb_stb_i = 1'b1;
      stall_force = (i == 1) && !stalled_once;
      s_wb_stall_i = stall_force;
      @(negedge clk);
      acc = !m1_wb_stall_o;
      step();
      if (acc) i++;
      else if (i == 1) stalled_once = 1'b1;
      guard++;
    end
    chk("t5_beats_issued", 32'(i), 32'h4);
    m1_wb_stb_i = 1'b0; stall_force = 1'b0; s_wb_stall_i = 1'b0;
    guard = 0;
    while (n_ack1 < 4 && guard < 20) begin step(); guard++; end
    m1_wb_cyc_i = 1'b0; m1_wb_we_i = 1'b0;
    step(); step();
    chk("t5_m1_acks", 32'(n_ack1), 32'h4);
    chk("t5_m0_acks", 32'(n_ack0), 32'h0);
    chk("t5_stalled", {31'h0, stalled_once}, 32'h1);
    chk("t5_nadr", 32'(adr_log.size()), 32'h4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t5_adr%0d", k), (k < adr_log.size()) ? adr_log[k] : 32'h0,
          32'h0000_2000 + (32'(k) << 2));
    end

    // Stray ack in IDLE is discarded
    ack_force = 1'b1;
    step();
    ack_force = 1'b0;
    @(negedge clk);
    chk("t6_m0_ack", {31'h0, m0_wb_ack_o}, 32'h0);
    chk("t6_m1_ack", {31'h0, m1_wb_ack_o}, 32'h0);
    step(); step();

    // Asynchronous reset during GRANT1 with stb high
    m1_wb_cyc_i = 1'b1; m1_wb_stb_i = 1'b1; m1_wb_adr_i = 32'h0000_3000;
    step(); step();
    @(negedge clk);
    chk("t7_granted", {30'h0, grant_o}, 32'h2);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("t7_rst_cyc", {31'h0, s_wb_cyc_o}, 32'h0);
    chk("t7_rst_stb", {31'h0, s_wb_stb_o}, 32'h0);
    chk("t7_rst_adr", s_wb_adr_o, 32'h0);
    chk("t7_rst_grant", {30'h0, grant_o}, 32'h0);
    chk("t7_rst_stall", {31'h0, m1_wb_stall_o}, 32'h1);
    chk("t7_rst_ack", {31'h0, m1_wb_ack_o}, 32'h0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t7_post_idle", {30'h0, grant_o}, 32'h0);
    step();
    @(negedge clk);
    chk("t7_regrant", {30'h0, grant_o}, 32'h2);
    chk("t7_regrant_cyc", {31'h0, s_wb_cyc_o}, 32'h1);
    m1_wb_stb_i = 1'b0;
    step();
    m1_wb_cyc_i = 1'b0;
    step(); step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
